// File: rtl/i2c_start_arb.sv
// i2c_start_arb: round-robin arbiter granting NUM_CH control channels access to one I2C main state machine.
// Optional START-phase timeout is enabled by defining I2C_START_ARB_TIMEOUT_EN.
module i2c_start_arb #(
  parameter int NUM_CH    = 4,
  parameter int TO_CYCLES = 200,
  parameter int ID_W      = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] START_I2C,
  input  logic              BUSY_MAIN_SM,
  output logic              START_MAIN_SM,
  output logic [ID_W-1:0]   GRANT_ID,
  output logic [NUM_CH-1:0] BUSY,
  output logic [NUM_CH-1:0] DONE,
  output logic [NUM_CH-1:0] TIMEOUT_ERR
);
  typedef enum logic [1:0] {IDLE, START, BUSYHIGH} state_t;
  state_t state, state_nxt;
  logic [NUM_CH-1:0] pending, grant_oh, own_oh, done_nxt, to_nxt;
  logic [ID_W-1:0] ptr, sel;
  logic found, grant;
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (!found && pending[(int'(ptr) + k) % NUM_CH]) begin
        found = 1'b1;
        sel = ID_W'((int'(ptr) + k) % NUM_CH);
      end
  end
  assign grant         = (state == IDLE) && !BUSY_MAIN_SM && found;
  assign grant_oh      = grant ? (NUM_CH'(1) << sel) : '0;
  assign own_oh        = NUM_CH'(1) << GRANT_ID;
  assign START_MAIN_SM = (state == START);
  assign BUSY          = pending | ((state != IDLE) ? own_oh : '0);
`ifdef I2C_START_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  logic        expired;
  assign expired = (cnt == 16'(TO_CYCLES - 1));
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) cnt <= '0;
    else if (grant) cnt <= '0;
    else if (state == START) cnt <= cnt + 16'd1;
`else
  logic expired;
  assign expired = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    done_nxt = '0;
    to_nxt = '0;
    case (state)
      IDLE: state_nxt = grant ? START : IDLE;
      START:
        if (BUSY_MAIN_SM) state_nxt = BUSYHIGH;
        else if (expired) begin
          state_nxt = IDLE;
          to_nxt = own_oh;
        end
      BUSYHIGH:
        if (!BUSY_MAIN_SM) begin
          state_nxt = IDLE;
          done_nxt = own_oh;
        end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      pending <= '0;
      ptr <= '0;
      GRANT_ID <= '0;
      DONE <= '0;
      TIMEOUT_ERR <= '0;
    end else begin
      state <= state_nxt;
      pending <= (pending | START_I2C) & ~grant_oh;
      DONE <= done_nxt;
      TIMEOUT_ERR <= to_nxt;
      if (grant) begin
        GRANT_ID <= sel;
        ptr <= ID_W'((int'(sel) + 1) % NUM_CH);
      end
    end
endmodule

// File: tb/tb_i2c_start_arb.sv
// tb_i2c_start_arb: directed self-checking bench for i2c_start_arb (NUM_CH=4, TO_CYCLES=8).
module tb_i2c_start_arb;
  logic       CLK = 1'b0, RST_N = 1'b0, BUSY_MAIN_SM = 1'b0;
  logic [3:0] START_I2C = '0;
  logic       START_MAIN_SM;
  logic [1:0] GRANT_ID;
  logic [3:0] BUSY, DONE, TIMEOUT_ERR;
  int checks = 0, errors = 0;
  i2c_start_arb #(.NUM_CH(4), .TO_CYCLES(8), .ID_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .START_I2C(START_I2C), .BUSY_MAIN_SM(BUSY_MAIN_SM),
    .START_MAIN_SM(START_MAIN_SM), .GRANT_ID(GRANT_ID), .BUSY(BUSY), .DONE(DONE),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );
  always #5 CLK = ~CLK;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    RST_N = 1'b0;
    START_I2C = '0;
    BUSY_MAIN_SM = 1'b0;
    tick(2);
    RST_N = 1'b1;
    tick();
  endtask
  task automatic pulse(input logic [3:0] req);
    START_I2C = req;
    tick();
    START_I2C = '0;
  endtask
  // Main SM model: acknowledges START, stays busy 4 cycles, optional request injected while busy.
  task automatic serve(input int id, input logic [3:0] inj);
    int n = 0;
    while (!START_MAIN_SM && n < 20) begin
      tick();
      n++;
    end
    chk("start_seen", START_MAIN_SM, 1);
    chk("grant_id", GRANT_ID, id);
    chk("busy_own", BUSY[id], 1);
    BUSY_MAIN_SM = 1'b1;
    tick();
    chk("start_drop", START_MAIN_SM, 0);
    pulse(inj);
    tick(2);
    BUSY_MAIN_SM = 1'b0;
    tick();
    chk("done_pulse", DONE, 4'b1 << id);
    chk("busy_at_done", BUSY[id], inj[id]);
    tick();
    chk("done_clear", DONE, 0);
  endtask
  initial begin
    bit ok;
    #2;
    chk("rst_start", START_MAIN_SM, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_to", TIMEOUT_ERR, 0);
    chk("rst_gid", GRANT_ID, 0);
    do_reset();
    // single request on channel 2
    pulse(4'b0100);
    chk("t1_pend_busy", BUSY, 4'b0100);
    chk("t1_no_start_yet", START_MAIN_SM, 0);
    tick();
    chk("t1_start_c1", START_MAIN_SM, 1);
    chk("t1_gid", GRANT_ID, 2);
    tick();
    chk("t1_start_c2", START_MAIN_SM, 1);
    tick();
    chk("t1_start_c3", START_MAIN_SM, 1);
    BUSY_MAIN_SM = 1'b1;
    tick();
    chk("t1_start_off", START_MAIN_SM, 0);
    ok = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      ok &= (BUSY == 4'b0100) && (DONE == 0) && !START_MAIN_SM;
    end
    chk("t1_busyhigh_hold", ok, 1);
    BUSY_MAIN_SM = 1'b0;
    tick();
    chk("t1_done", DONE, 4'b0100);
    chk("t1_busy_off", BUSY, 0);
    tick();
    chk("t1_done_once", DONE, 0);
    // contention 1011 from a fresh pointer, channel 0 re-requests during channel 1
    do_reset();
    pulse(4'b1011);
    chk("t2_pend", BUSY, 4'b1011);
    serve(0, 4'b0000);
    serve(1, 4'b0001);
    serve(3, 4'b0000);
    serve(0, 4'b0000);
    // re-request during own BUSYHIGH
    pulse(4'b0010);
    serve(1, 4'b0010);
    serve(1, 4'b0000);
    chk("t3_idle_busy", BUSY, 0);
    // foreign occupancy
    BUSY_MAIN_SM = 1'b1;
    pulse(4'b0001);
    ok = 1;
    for (int i = 0; i < 19; i++) begin
      tick();
      ok &= !START_MAIN_SM && (BUSY == 4'b0001);
    end
    chk("t4_held", ok, 1);
    BUSY_MAIN_SM = 1'b0;
    tick();
    chk("t4_start_after", START_MAIN_SM, 1);
    serve(0, 4'b0000);
    // START phase with no acknowledge on channel 3
    pulse(4'b1000);
    tick();
    chk("t5_start", START_MAIN_SM, 1);
    chk("t5_gid", GRANT_ID, 3);
    ok = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      ok &= START_MAIN_SM && (TIMEOUT_ERR == 0);
    end
    chk("t5_start_8cyc", ok, 1);
    tick();
`ifdef I2C_START_ARB_TIMEOUT_EN
    chk("t5_start_off", START_MAIN_SM, 0);
    chk("t5_to", TIMEOUT_ERR, 4'b1000);
    chk("t5_no_done", DONE, 0);
    chk("t5_busy_off", BUSY, 0);
    tick();
    chk("t5_to_once", TIMEOUT_ERR, 0);
`else
    chk("t5_start_stays", START_MAIN_SM, 1);
    chk("t5_no_to", TIMEOUT_ERR, 0);
`endif
    // reset in BUSYHIGH with channels 1 and 2 pending
    do_reset();
    pulse(4'b0001);
    tick();
    BUSY_MAIN_SM = 1'b1;
    tick();
    pulse(4'b0110);
    chk("t6_busy_pre", BUSY, 4'b0111);
    #2 RST_N = 1'b0;
    #1;
    chk("t6_start", START_MAIN_SM, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_gid", GRANT_ID, 0);
    BUSY_MAIN_SM = 1'b0;
    tick();
    chk("t6_done", DONE | TIMEOUT_ERR, 0);
    RST_N = 1'b1;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      ok &= !START_MAIN_SM && (BUSY == 0) && (DONE == 0);
    end
    chk("t6_no_grant", ok, 1);
    pulse(4'b0100);
    serve(2, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
